// File: rtl/seq_detector_param_if.sv
// Bundles the serial data, configuration and result signals of seq_detector_param.
// The master modport drives bits and configuration; the slave modport is the detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               din_valid;
    logic               din;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               dout;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
        input  dout, cfg_err, match_cnt
    );

    modport slave (
        input  din_valid, din, cfg_we, cfg_pattern, cfg_len, cfg_overlap,
        output dout, cfg_err, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector (Moore). The first-received bit of the pattern
// is pattern[len-1], the last is pattern[0]. dout is a registered one-cycle pulse.
// Optional match counter: define SEQ_DETECTOR_MATCH_CNT_EN to build it; otherwise
// match_cnt is tied to 0.
module seq_detector_param #(
    parameter int                 MAX_LEN         = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1101),
    parameter int                 DEFAULT_LEN     = 4,
    parameter int                 CNT_W           = 16
) (
    input logic                 clk,
    input logic                 clr,
    seq_detector_param_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {FILL, ARMED, MATCH} state_t;

    state_t             state;
    state_t             state_next;
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] history_shift;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               cfg_err;
    logic               cfg_ok;
    logic               cfg_accept;
    logic               bit_take;
    logic               hit;
    logic               match_edge;

    // Match detection: compare the low len bits of the would-be history against the pattern.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        history_shift = {history[MAX_LEN-2:0], bus.din};
        cfg_ok        = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        cfg_accept    = bus.cfg_we && cfg_ok;
        bit_take      = bus.din_valid && !cfg_accept;
        hit           = (({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len}) &&
                        ((history_shift & mask) == (pattern & mask));
        match_edge    = bit_take && hit;
        fill_inc      = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    end

    // Next fill level and next FSM state; a fresh match always lands in MATCH for one cycle.
    always_comb begin
        fill_next  = fill;
        state_next = state;
        if (cfg_accept) begin
            fill_next = '0;
        end else if (bit_take) begin
            fill_next = (match_edge && !overlap) ? '0 : fill_inc;
        end
        state_next = (fill_next >= len) ? ARMED : FILL;
        if (match_edge) begin
            state_next = MATCH;
        end
    end

    // State, history, configuration and error-pulse registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= FILL;
            history <= '0;
            fill    <= '0;
            pattern <= DEFAULT_PATTERN;
            len     <= LEN_W'(DEFAULT_LEN);
            overlap <= 1'b1;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            fill    <= fill_next;
            cfg_err <= bus.cfg_we && !cfg_ok;
            if (cfg_accept) begin
                history <= '0;
                pattern <= bus.cfg_pattern;
                len     <= bus.cfg_len;
                overlap <= bus.cfg_overlap;
            end else if (bit_take) begin
                history <= history_shift;
            end
        end
    end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;

    // Saturating match counter; survives config writes, cleared only by reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            match_cnt <= '0;
        end else if (match_edge && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = match_cnt;
`else
    assign bus.match_cnt = '0;
`endif

    assign bus.dout    = (state == MATCH);
    assign bus.cfg_err = cfg_err;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a queue-of-bits model predicts dout,
// cfg_err and match_cnt for every driven cycle; results are compared after the edge.
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic             dout;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic clr;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    exp_t       sb[$];
    int         recv[$];
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    int         m_cnt;
    int         total;
    int         bad;
    int         pulses;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the active edge.
    task automatic applyStimulus(input logic v, input logic b, input logic we,
                                 input logic [7:0] pat, input int len, input logic ovl);
        exp_t e;
        bit   hit;
        @(negedge clk);
        bus.din_valid   = v;
        bus.din         = b;
        bus.cfg_we      = we;
        bus.cfg_pattern = pat;
        bus.cfg_len     = 4'(len);
        bus.cfg_overlap = ovl;
        e.dout = 1'b0;
        e.err  = 1'b0;
        if (we && len >= 1 && len <= MAX_LEN) begin
            m_pat = pat;
            m_len = len;
            m_ovl = ovl;
            recv.delete();
        end else begin
            if (we) e.err = 1'b1;
            if (v) begin
                recv.push_back(int'(b));
                if (recv.size() > MAX_LEN) void'(recv.pop_front());
                hit = 1'b0;
                if (recv.size() >= m_len) begin
                    hit = 1'b1;
                    for (int i = 0; i < m_len; i++) begin
                        if (recv[recv.size() - m_len + i] != int'(m_pat[m_len - 1 - i])) hit = 1'b0;
                    end
                end
                if (hit) begin
                    e.dout = 1'b1;
                    if (CNT_EN && m_cnt < CNT_MAX) m_cnt++;
                    if (!m_ovl) recv.delete();
                end
            end
        end
        e.cnt = CNT_W'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("dout", 32'(bus.dout), 32'(e.dout));
        checkOutput("cfg_err", 32'(bus.cfg_err), 32'(e.err));
        checkOutput("match_cnt", 32'(bus.match_cnt), 32'(e.cnt));
        if (bus.dout === 1'b1) pulses++;
        bus.din_valid = 1'b0;
        bus.cfg_we    = 1'b0;
    endtask

    task automatic sendBits(input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic gap();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic writeCfg(input logic [7:0] pat, input int len, input logic ovl);
        applyStimulus(1'b0, 1'b0, 1'b1, pat, len, ovl);
    endtask

    task automatic checkPulses(input string tag, input int n);
        checkOutput(tag, 32'(pulses), 32'(n));
        pulses = 0;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic resetDut();
        clr = 1'b0;
        #1;
        checkOutput("clr_dout", 32'(bus.dout), 32'd0);
        checkOutput("clr_err", 32'(bus.cfg_err), 32'd0);
        checkOutput("clr_cnt", 32'(bus.match_cnt), 32'd0);
        recv.delete();
        m_pat  = 8'b0000_1101;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_cnt  = 0;
        pulses = 0;
        @(negedge clk);
        #2;
        clr = 1'b1;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        pulses          = 0;
        clr             = 1'b0;
        bus.din_valid   = 1'b0;
        bus.din         = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        #12;
        resetDut();

        // Defaults detect 1,1,0,1.
        sendBits(4, 16'b1101);
        checkPulses("t1_pulses", 1);
        checkOutput("t1_cnt", 32'(bus.match_cnt), CNT_EN ? 32'd1 : 32'd0);
        sendBits(4, 16'b1101);
        checkOutput("t1_dout_high", 32'(bus.dout), 32'd1);
        resetDut();

        // Overlapping matches.
        writeCfg(8'b0000_1101, 4, 1'b1);
        sendBits(7, 16'b1101101);
        checkPulses("ovl_pulses", 2);

        // Non-overlapping matches.
        writeCfg(8'b0000_1101, 4, 1'b0);
        sendBits(7, 16'b1101101);
        checkPulses("novl_7bit_pulses", 1);
        writeCfg(8'b0000_1101, 4, 1'b0);
        sendBits(8, 16'b1101_1101);
        checkPulses("novl_8bit_pulses", 2);

        // Full-length pattern with a misleading prefix.
        writeCfg(8'b1010_0110, 8, 1'b1);
        sendBits(12, 16'b0110_1010_0110);
        checkPulses("len8_pulses", 1);

        // Single-bit pattern; upper pattern bits are ignored.
        writeCfg(8'b1111_0001, 1, 1'b1);
        sendBits(3, 16'b101);
        checkPulses("len1_pulses", 2);

        // Rejected writes leave the previous configuration in place.
        writeCfg(8'b0000_1101, 4, 1'b1);
        writeCfg(8'b1111_1111, 0, 1'b0);
        writeCfg(8'b1111_1111, MAX_LEN + 1, 1'b0);
        sendBits(4, 16'b1101);
        checkPulses("bad_cfg_pulses", 1);

        // Valid gaps do not break a match.
        writeCfg(8'b0000_1101, 4, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        gap();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        gap();
        gap();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        gap();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        gap();
        checkPulses("gap_pulses", 1);

        // Reset mid-sequence discards partial history.
        sendBits(3, 16'b110);
        resetDut();
        sendBits(1, 16'b1);
        checkPulses("midclr_pulses", 0);

        // Counter saturation.
        resetDut();
        sendBits(16, 16'b1101_1101_1101_1101);
        checkPulses("sat_pulses", 4);
        checkOutput("sat_cnt", 32'(bus.match_cnt), CNT_EN ? 32'(CNT_MAX) : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
